valu_alpha_sequencer: RTL and testbench

- Multi-cycle controller that sequences the shared 128-bit vector ALU to compute one alpha-composited vector per job.
- Blend: out = (fg*alpha + bg*(MAX-alpha)) / MAX, lane-wise, where MAX = 2^LANE-1.
- Sits between the vector register read stage (job source, valid/ready) and writeback (result sink, valid/ready).
- Drives the ALU's A, B and Sel inputs and captures its C output. Lane arithmetic, truncation and division-by-zero handling belong to the ALU; this block only routes operands and temporaries.

---
 rtl/valu_alpha_sequencer_if.sv | 25 ++
 rtl/valu_alpha_sequencer.sv | 145 ++++++++++++++
 tb/tb_valu_alpha_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/valu_alpha_sequencer_if.sv
// Job-in / result-out handshake bundle between the vector register read stage,
// the alpha sequencer and writeback.
interface valu_alpha_sequencer_if #(
   parameter int N = 128
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_mode;
   logic [N-1:0] in_fg;
   logic [N-1:0] in_bg;
   logic [N-1:0] in_alpha;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   modport slave (
      input  in_valid, in_mode, in_fg, in_bg, in_alpha, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_mode, in_fg, in_bg, in_alpha, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/valu_alpha_sequencer.sv
// Sequences the shared vector ALU through inv/mul/mul/add/div to produce one
// alpha-blended vector per job; pass/clear jobs take a single ALU cycle.
module valu_alpha_sequencer #(
   parameter int N    = 128,
   parameter int LANE = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   valu_alpha_sequencer_if.slave   job,
   output logic [N-1:0]            alu_a,
   output logic [N-1:0]            alu_b,
   output logic [2:0]              alu_sel,
   input  logic [N-1:0]            alu_c,
   output logic                    busy,
   output logic [15:0]             job_count
);

   localparam logic [N-1:0] MAX = {(N/LANE){{LANE{1'b1}}}};

   localparam logic [2:0] SEL_ZERO = 3'd0;
   localparam logic [2:0] SEL_A    = 3'd1;
   localparam logic [2:0] SEL_ADD  = 3'd2;
   localparam logic [2:0] SEL_SUB  = 3'd3;
   localparam logic [2:0] SEL_MUL  = 3'd4;
   localparam logic [2:0] SEL_DIV  = 3'd5;
   localparam logic [2:0] SEL_B    = 3'd7;

   typedef enum logic [2:0] {
      IDLE, INV, MUL_FG, MUL_BG, ADD, DIV, SINGLE, DONE
   } state_t;

   state_t       state, state_n;
   logic [1:0]   mode_q;
   logic [N-1:0] fg_q, bg_q, alpha_q, inv_q, p1_q, p2_q;
   logic [N-1:0] out_data_q;
   logic         out_valid_q;
   logic [15:0]  job_cnt;

   assign job.in_ready  = (state == IDLE);
   assign job.out_valid = out_valid_q;
   assign job.out_data  = out_data_q;
   assign busy          = (state != IDLE);
   assign job_count     = job_cnt;

   always_comb begin
      state_n = state;
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = SEL_ZERO;
      case (state)
         IDLE: begin
            if (job.in_valid) state_n = (job.in_mode == 2'd0) ? INV : SINGLE;
         end
         INV: begin
            alu_a   = MAX;
            alu_b   = alpha_q;
            alu_sel = SEL_SUB;
            state_n = MUL_FG;
         end
         MUL_FG: begin
            alu_a   = fg_q;
            alu_b   = alpha_q;
            alu_sel = SEL_MUL;
            state_n = MUL_BG;
         end
         MUL_BG: begin
            alu_a   = bg_q;
            alu_b   = inv_q;
            alu_sel = SEL_MUL;
            state_n = ADD;
         end
         ADD: begin
            alu_a   = p1_q;
            alu_b   = p2_q;
            alu_sel = SEL_ADD;
            state_n = DIV;
         end
         DIV: begin
            alu_a   = p1_q;
            alu_b   = MAX;
            alu_sel = SEL_DIV;
            state_n = DONE;
         end
         SINGLE: begin
            alu_a = fg_q;
            alu_b = bg_q;
            case (mode_q)
               2'd1:    alu_sel = SEL_A;
               2'd2:    alu_sel = SEL_B;
               default: alu_sel = SEL_ZERO;
            endcase
            state_n = DONE;
         end
         DONE: begin
            if (job.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // p1 doubles as the sum register in ADD, so DIV reads the sum from p1
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mode_q      <= 2'd0;
         fg_q        <= '0;
         bg_q        <= '0;
         alpha_q     <= '0;
         inv_q       <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         job_cnt     <= 16'd0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (job.in_valid) begin
                  mode_q  <= job.in_mode;
                  fg_q    <= job.in_fg;
                  bg_q    <= job.in_bg;
                  alpha_q <= job.in_alpha;
               end
            end
            INV:    inv_q <= alu_c;
            MUL_FG: p1_q  <= alu_c;
            MUL_BG: p2_q  <= alu_c;
            ADD:    p1_q  <= alu_c;
            DIV, SINGLE: begin
               out_data_q  <= alu_c;
               out_valid_q <= 1'b1;
            end
            DONE: begin
               if (job.out_ready) begin
                  out_valid_q <= 1'b0;
                  job_cnt     <= job_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_valu_alpha_sequencer.sv
// Directed bench for valu_alpha_sequencer with a lane-wise 8-bit ALU model
// attached and a scoreboard queue of expected results.
module tb_valu_alpha_sequencer;

   localparam int N = 128;
   localparam logic [N-1:0] MAX = {16{8'hFF}};

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] alu_a, alu_b, alu_c;
   logic [2:0]   alu_sel;
   logic         busy;
   logic [15:0]  job_count;

   int           tests = 0;
   int           fails = 0;
   int           hs_count = 0;
   int           exp_hs = 0;
   logic [15:0]  exp_jobs = 16'd0;
   logic [N-1:0] sb[$];

   valu_alpha_sequencer_if #(.N(N)) bus ();

   valu_alpha_sequencer #(.N(N), .LANE(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .job       (bus),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_c     (alu_c),
      .busy      (busy),
      .job_count (job_count)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [2:0] sel);
      logic [N-1:0] res;
      logic [7:0]   x, y, r;
      res = '0;
      for (int i = 0; i < N/8; i++) begin
         x = a[i*8 +: 8];
         y = b[i*8 +: 8];
         case (sel)
            3'd1:    r = x;
            3'd2:    r = x + y;
            3'd3:    r = x - y;
            3'd4:    r = x * y;
            3'd5:    r = (y == 8'd0) ? 8'hFF : x / y;
            3'd7:    r = y;
            default: r = 8'd0;
         endcase
         res[i*8 +: 8] = r;
      end
      return res;
   endfunction

   assign alu_c = alu_model(alu_a, alu_b, alu_sel);

   always @(posedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) hs_count++;
   end

   function automatic logic [N-1:0] rnd_vec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      if (sb.size() == 0) check("scoreboard_nonempty", 0, 1);
      else check("out_data", bus.out_data, sb.pop_front());
   endtask

   task automatic alu_step(input string tag, input logic [2:0] sel, input logic [N-1:0] a,
                           input logic [N-1:0] b, input bit vary);
      check({tag, "_sel"}, alu_sel, sel);
      check({tag, "_a"}, alu_a, a);
      check({tag, "_b"}, alu_b, b);
      check({tag, "_valid"}, bus.out_valid, 0);
      if (vary) begin
         bus.in_fg    = rnd_vec();
         bus.in_alpha = rnd_vec();
         bus.in_bg    = rnd_vec();
      end
      tick();
   endtask

   task automatic accept(input logic [1:0] mode, input logic [N-1:0] fg, input logic [N-1:0] bg,
                         input logic [N-1:0] al);
      bus.in_mode  = mode;
      bus.in_fg    = fg;
      bus.in_bg    = bg;
      bus.in_alpha = al;
      bus.in_valid = 1'b1;
      check("accept_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic finish_job();
      check("done_valid", bus.out_valid, 1);
      check_out();
      check("done_busy", busy, 1);
      check("done_ready", bus.in_ready, 0);
      check("done_sel", alu_sel, 0);
      bus.out_ready = 1'b1;
      tick();
      exp_jobs = exp_jobs + 16'd1;
      exp_hs++;
      check("post_valid", bus.out_valid, 0);
      check("post_count", job_count, exp_jobs);
      check("post_ready", bus.in_ready, 1);
   endtask

   task automatic run_blend(input logic [N-1:0] fg, input logic [N-1:0] bg,
                            input logic [N-1:0] al, input bit vary);
      logic [N-1:0] inv, p1, p2, s;
      inv = alu_model(MAX, al, 3'd3);
      p1  = alu_model(fg, al, 3'd4);
      p2  = alu_model(bg, inv, 3'd4);
      s   = alu_model(p1, p2, 3'd2);
      bus.out_ready = 1'b1;
      accept(2'd0, fg, bg, al);
      sb.push_back(alu_model(s, MAX, 3'd5));
      alu_step("inv", 3'd3, MAX, al, vary);
      alu_step("mul_fg", 3'd4, fg, al, vary);
      alu_step("mul_bg", 3'd4, bg, inv, vary);
      alu_step("add", 3'd2, p1, p2, vary);
      alu_step("div", 3'd5, s, MAX, vary);
      finish_job();
   endtask

   task automatic run_single(input logic [1:0] mode, input logic [N-1:0] fg, input logic [N-1:0] bg,
                             input logic [2:0] sel);
      accept(mode, fg, bg, '0);
      case (mode)
         2'd1:    sb.push_back(fg);
         2'd2:    sb.push_back(bg);
         default: sb.push_back('0);
      endcase
      alu_step("single", sel, fg, bg, 1'b0);
   endtask

   initial begin
      logic [N-1:0] hold_fg;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_mode   = 2'd0;
      bus.in_fg     = '0;
      bus.in_bg     = '0;
      bus.in_alpha  = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", bus.in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_count", job_count, 0);

      run_blend({16{8'hC8}}, {16{8'h32}}, {16{8'h40}}, 1'b0);

      bus.out_ready = 1'b1;
      run_single(2'd1, {8{16'h1234}}, {8{16'hABCD}}, 3'd1);
      finish_job();
      run_single(2'd2, {8{16'h1234}}, {8{16'hABCD}}, 3'd7);
      finish_job();
      run_single(2'd3, {8{16'h1234}}, {8{16'hABCD}}, 3'd0);
      finish_job();

      run_blend(rnd_vec(), rnd_vec(), rnd_vec(), 1'b1);
      run_blend({16{8'hFF}}, {16{8'h00}}, {16{8'hFF}}, 1'b0);

      bus.out_ready = 1'b0;
      hold_fg = rnd_vec() | 128'h1;
      run_single(2'd1, hold_fg, rnd_vec(), 3'd1);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", bus.out_valid, 1);
         check("bp_data", bus.out_data, hold_fg);
         check("bp_busy", busy, 1);
         check("bp_ready", bus.in_ready, 0);
         bus.in_valid = 1'b1;
         bus.in_mode  = 2'($urandom_range(0, 3));
         bus.in_fg    = rnd_vec();
         bus.in_bg    = rnd_vec();
         tick();
      end
      bus.in_valid = 1'b0;
      finish_job();
      tick();
      check("bp_idle_busy", busy, 0);

      bus.out_ready = 1'b1;
      accept(2'd0, rnd_vec(), rnd_vec(), rnd_vec());
      tick();
      tick();
      check("abort_in_mulbg_sel", alu_sel, 4);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_jobs = 16'd0;
      check("abort_ready", bus.in_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_valid", bus.out_valid, 0);
      check("abort_data", bus.out_data, 0);
      check("abort_count", job_count, 0);
      for (int i = 0; i < 8; i++) tick();
      check("abort_no_output", bus.out_valid, 0);

      force dut.job_cnt = 16'hFFFE;
      #1;
      release dut.job_cnt;
      exp_jobs = 16'hFFFE;
      check("preload_count", job_count, 16'hFFFE);
      run_single(2'd1, rnd_vec(), rnd_vec(), 3'd1);
      finish_job();
      check("count_ffff", job_count, 16'hFFFF);
      run_single(2'd2, rnd_vec(), rnd_vec(), 3'd7);
      finish_job();
      check("count_wrap", job_count, 16'h0000);

      tick();
      check("handshake_total", hs_count, exp_hs);
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
